// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end and the control unit:
// fetch FSM encoding, the NOP word, opcode constants and the branch offset helper.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Opcodes the control unit decodes into Jump / Branch.
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  // Sign-extended word offset of a conditional branch, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: single outstanding word read, req held until ready.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  // Fetch unit side: issues requests, receives data.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  // Memory side: answers requests.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC calculator (pc_next_calc): purely combinational PC+4, branch target
// and jump target selection. Jump wins over a taken branch.
module instr_fetch_unit_pc_next_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_field,  // Instr[25:0]: jump index, low half is branch imm
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // All arithmetic wraps modulo 2^32; no overflow indication is wanted.
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + branch_offset(instr_field[15:0]);
  assign jump_target   = {pc_plus4[31:28], instr_field, 2'b00};

  // Priority select: jump, then taken branch, then sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads one word per instruction from
// instruction memory and holds it for the core until the core advances.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master imem,
  output logic [31:0]        Instr,
  output logic               instr_valid,
  output logic [31:0]        PC,
  output logic [31:0]        PCPlus4,
  input  logic               advance,
  input  logic               Branch,
  input  logic               Zero,
  input  logic               Jump
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;

  instr_fetch_unit_pc_next_calc u_pc_next (
    .pc          (pc_q),
    .instr_field (instr_q[25:0]),
    .branch      (Branch),
    .zero        (Zero),
    .jump        (Jump),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

  // Next-state logic: capture data on ready in FETCH, step the PC on advance in EXEC.
  // ready outside FETCH and advance outside EXEC fall through to the hold defaults.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (advance && valid_q) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Request is a pure decode of state so the address is stable for the whole wait.
  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;

  assign Instr       = instr_q;
  assign instr_valid = valid_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Instance a uses the default reset PC;
// instance b resets to 0x30000010 so jump targets in an upper region can be checked.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [31:0] rdata;
  logic        advance, br, zero, jump;

  logic [31:0] instr_a, pc_a, pc4_a;
  logic        valid_a;
  logic [31:0] instr_b, pc_b, pc4_b;
  logic        valid_b;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit_if ia ();
  instr_fetch_unit_if ib ();

  assign ia.imem_ready = ready;
  assign ia.imem_rdata = rdata;
  assign ib.imem_ready = ready;
  assign ib.imem_rdata = rdata;

  instr_fetch_unit dut_a (
    .clk(clk), .reset(reset), .imem(ia),
    .Instr(instr_a), .instr_valid(valid_a), .PC(pc_a), .PCPlus4(pc4_a),
    .advance(advance), .Branch(br), .Zero(zero), .Jump(jump)
  );

  instr_fetch_unit #(.RESET_PC(32'h3000_0010)) dut_b (
    .clk(clk), .reset(reset), .imem(ib),
    .Instr(instr_b), .instr_valid(valid_b), .PC(pc_b), .PCPlus4(pc4_b),
    .advance(advance), .Branch(br), .Zero(zero), .Jump(jump)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 ^ a;
  endfunction

  // Zero-wait streaming with ready and advance held high; starts in FETCH.
  task automatic stream(input logic [31:0] start, input int n);
    logic [31:0] a;
    ready = 1'b1; advance = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      rdata = mem_word(a);
      chk("st_req", {31'b0, ia.imem_req}, 32'd1);
      chk("st_addr", ia.imem_addr, a);
      chk("st_vlo", {31'b0, valid_a}, 32'd0);
      tick();
      chk("st_vhi", {31'b0, valid_a}, 32'd1);
      chk("st_instr", instr_a, mem_word(a));
      chk("st_reqlo", {31'b0, ia.imem_req}, 32'd0);
      tick();
      $display("stream fetch addr=%h instr=%h", a, mem_word(a));
    end
    ready = 1'b0; advance = 1'b0;
  endtask

  // One fetch + one stalled EXEC cycle + advance with given flags; starts in FETCH.
  task automatic fetch_exec(input logic [31:0] a, input logic [31:0] w,
                            input logic b_i, input logic z_i, input logic j_i,
                            input logic [31:0] nxt);
    ready = 1'b1; rdata = w; advance = 1'b0;
    chk("fx_req", {31'b0, ia.imem_req}, 32'd1);
    chk("fx_addr", ia.imem_addr, a);
    tick();
    chk("fx_valid", {31'b0, valid_a}, 32'd1);
    chk("fx_instr", instr_a, w);
    chk("fx_pc", pc_a, a);
    chk("fx_pc4", pc4_a, a + 32'd4);
    rdata = ~w;  // ready outside FETCH must not disturb Instr
    tick();
    chk("fx_hold", instr_a, w);
    chk("fx_vhold", {31'b0, valid_a}, 32'd1);
    ready = 1'b0;
    advance = 1'b1; br = b_i; zero = z_i; jump = j_i;
    tick();
    chk("fx_next", pc_a, nxt);
    chk("fx_vclr", {31'b0, valid_a}, 32'd0);
    chk("fx_req2", {31'b0, ia.imem_req}, 32'd1);
    advance = 1'b0; br = 1'b0; zero = 1'b0; jump = 1'b0;
    $display("txn pc=%h instr=%h B=%0b Z=%0b J=%0b -> next=%h", a, w, b_i, z_i, j_i, nxt);
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; rdata = 32'h0;
    advance = 1'b0; br = 1'b0; zero = 1'b0; jump = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_pc", pc_a, 32'h0);
    chk("rst_instr", instr_a, 32'h0);
    chk("rst_valid", {31'b0, valid_a}, 32'd0);
    chk("rst_req", {31'b0, ia.imem_req}, 32'd0);
    chk("rst_pc4", pc4_a, 32'h4);
    chk("rst_pc_b", pc_b, 32'h3000_0010);
    reset = 1'b0;
    chk("idle_req", {31'b0, ia.imem_req}, 32'd0);
    tick();
    chk("fetch_req", {31'b0, ia.imem_req}, 32'd1);
    chk("fetch_addr", ia.imem_addr, 32'h0);

    // Streaming, with wait states at PC=4 (advance held high, must be ignored in FETCH)
    stream(32'h0, 1);
    ready = 1'b0; advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", ia.imem_addr, 32'h4);
      chk("wait_req", {31'b0, ia.imem_req}, 32'd1);
      chk("wait_valid", {31'b0, valid_a}, 32'd0);
    end
    ready = 1'b1; rdata = mem_word(32'h4);
    tick();
    chk("wait_cap", instr_a, mem_word(32'h4));
    chk("wait_vhi", {31'b0, valid_a}, 32'd1);
    ready = 1'b0;
    tick();
    chk("wait_adv", pc_a, 32'h8);
    $display("wait-state fetch addr=00000004 done");
    stream(32'h8, 2);
    chk("stream_end", pc_a, 32'h10);

    // Branches
    fetch_exec(32'h10, 32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'h0C);
    fetch_exec(32'h0C, 32'h0, 1'b0, 1'b0, 1'b0, 32'h10);
    fetch_exec(32'h10, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h14);
    fetch_exec(32'h14, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'h18);

    // Reset mid-fetch; ready pulses during and just after reset are ignored
    tick();
    chk("mf_req", {31'b0, ia.imem_req}, 32'd1);
    reset = 1'b1; ready = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    chk("mf_pc", pc_a, 32'h0);
    chk("mf_req0", {31'b0, ia.imem_req}, 32'd0);
    chk("mf_valid", {31'b0, valid_a}, 32'd0);
    chk("mf_instr", instr_a, 32'h0);
    reset = 1'b0;
    tick();
    chk("mf_pulse_v", {31'b0, valid_a}, 32'd0);
    chk("mf_pulse_i", instr_a, 32'h0);
    chk("mf_refetch", {31'b0, ia.imem_req}, 32'd1);
    $display("reset during fetch handled");

    // Jump from 0x30000010 (instance b), then jump with taken branch also set
    for (int k = 0; k < 2; k++) begin
      ready = 1'b1; rdata = 32'h0800_0040;
      chk("j_addr_b", ib.imem_addr, 32'h3000_0010);
      tick();
      ready = 1'b0;
      chk("j_instr_b", instr_b, 32'h0800_0040);
      advance = 1'b1; jump = 1'b1; br = (k == 1); zero = (k == 1);
      tick();
      chk("j_pc_b", pc_b, 32'h3000_0100);
      chk("j_pc_a", pc_a, 32'h0000_0100);
      advance = 1'b0; jump = 1'b0; br = 1'b0; zero = 1'b0;
      $display("jump txn k=%0d pc_b=%h pc_a=%h", k, pc_b, pc_a);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
    end

    // Wrap: branch back from 0 to 0xFFFFFFFC, then sequential wraps to 0
    fetch_exec(32'h0, 32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC);
    fetch_exec(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
